// File: rtl/cnt_cmd_seq.sv
// Command sequencer for a loadable 8-bit counter: queues LOAD/RUN/RUN_UNTIL/CLEAR
// commands in a small FIFO and drives the counter's ENA/LOAD/DATA controls one command at a time.
module cnt_cmd_seq #(
    parameter int DEPTH = 4,
    parameter int TMO   = 256
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [1:0] cmd_op_i,
    input  logic [7:0] cmd_arg_i,
    input  logic [7:0] cnt_i,
    output logic       ena_o,
    output logic [2:0] load_o,
    output logic [7:0] data_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TMO);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TMO - 1);

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_RUN   = 2'b01,
        OP_UNTIL = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        LD_NONE  = 3'b000,
        LD_DATA  = 3'b001,
        LD_CLEAR = 3'b010
    } load_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_RUN,
        S_UNTIL,
        S_FIN
    } state_e;

    typedef struct packed {
        op_e        op;
        logic [7:0] arg;
    } cmd_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    cmd_t            mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q, count_d;
    logic            push, pop;
    cmd_t            head;
    state_e          state_q;

    assign cmd_ready_o = (count_q != (AW+1)'(DEPTH));
    assign push        = cmd_valid_i && cmd_ready_o;
    assign pop         = (state_q == S_IDLE) && (count_q != '0);
    assign head        = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: the storage array carries no reset; emptiness is defined by count_q alone,
    // so stale entries are never read and the array maps onto plain RAM/flops without reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_t'({cmd_op_i, cmd_arg_i});
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Execution FSM with registered control outputs
    // ------------------------------------------------------------------
    logic          ena_q;
    load_e         load_q;
    logic [7:0]    data_q;
    logic          done_q;
    logic          err_q;
    logic [7:0]    arg_q;
    logic [7:0]    remain_q;
    logic [TW-1:0] timer_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            ena_q    <= 1'b0;
            load_q   <= LD_NONE;
            data_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            arg_q    <= '0;
            remain_q <= '0;
            timer_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        arg_q <= head.arg;
                        unique case (head.op)
                            OP_LOAD: begin
                                load_q  <= LD_DATA;
                                data_q  <= head.arg;
                                state_q <= S_EXEC;
                            end
                            OP_CLEAR: begin
                                load_q  <= LD_CLEAR;
                                state_q <= S_EXEC;
                            end
                            OP_RUN: begin
                                if (head.arg == 8'd0) begin
                                    done_q  <= 1'b1;
                                    state_q <= S_FIN;
                                end else begin
                                    ena_q    <= 1'b1;
                                    remain_q <= head.arg;
                                    state_q  <= S_RUN;
                                end
                            end
                            OP_UNTIL: begin
                                if (cnt_i == head.arg) begin
                                    done_q  <= 1'b1;
                                    state_q <= S_FIN;
                                end else begin
                                    ena_q   <= 1'b1;
                                    timer_q <= '0;
                                    state_q <= S_UNTIL;
                                end
                            end
                        endcase
                    end
                end
                S_EXEC: begin
                    load_q  <= LD_NONE;
                    data_q  <= '0;
                    done_q  <= 1'b1;
                    state_q <= S_FIN;
                end
                S_RUN: begin
                    if (remain_q == 8'd1) begin
                        ena_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_FIN;
                    end else begin
                        remain_q <= remain_q - 8'd1;
                    end
                end
                S_UNTIL: begin
                    // Stop one count early: the counter still increments on this edge.
                    if (cnt_i == arg_q - 8'd1) begin
                        ena_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_FIN;
                    end else if (timer_q == TIMER_LAST) begin
                        ena_q   <= 1'b0;
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_FIN;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ena_o  = ena_q;
    assign load_o = load_q;
    assign data_o = data_q;
    assign done_o = done_q;
    assign err_o  = err_q;
    assign busy_o = (state_q != S_IDLE) || (count_q != '0);

endmodule
